// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard tracker for the D stage.
// Holds {valid, dst, tnew} for slots 1 (E) .. DEPTH (W) and a multiply/divide
// busy counter. Stall outputs are combinational from the slots, the counter and
// the D-stage inputs.
// Build option: define HAZARD_FORWARD_EN to stall only while the producer's
// result is not yet forwardable (Tuse < Tnew). Without it, any register match
// in slots 1..DEPTH-1 stalls, and slot DEPTH is covered by register-file
// write-through.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int TW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_wdst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic              stall_md,
  output logic              md_busy
);

  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [TW-1:0] NOTUSE  = '1;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT);

  logic              valid_q [1:DEPTH];
  logic              valid_d [1:DEPTH];
  logic [REG_AW-1:0] dst_q   [1:DEPTH];
  logic [REG_AW-1:0] dst_d   [1:DEPTH];
  logic [TW-1:0]     tnew_q  [1:DEPTH];
  logic [TW-1:0]     tnew_d  [1:DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hit_rs, hit_rt;

  // Source-vs-slot match; the stall rule depends on the forwarding build.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (valid_q[k] && (dst_q[k] != '0)) begin
`ifdef HAZARD_FORWARD_EN
        if ((dst_q[k] == d_rs) && (d_tuse_rs != NOTUSE) && (d_tuse_rs < tnew_q[k]))
          hit_rs = 1'b1;
        if ((dst_q[k] == d_rt) && (d_tuse_rt != NOTUSE) && (d_tuse_rt < tnew_q[k]))
          hit_rt = 1'b1;
`else
        if ((k < DEPTH) && (dst_q[k] == d_rs) && (d_tuse_rs != NOTUSE))
          hit_rs = 1'b1;
        if ((k < DEPTH) && (dst_q[k] == d_rt) && (d_tuse_rt != NOTUSE))
          hit_rt = 1'b1;
`endif
      end
    end
  end

  // Stall outputs; nothing stalls unless D holds a valid instruction.
  always_comb begin
    stall_rs = d_valid & hit_rs;
    stall_rt = d_valid & hit_rt;
    md_busy  = (cnt_q != '0);
    stall_md = d_valid & d_md_use & md_busy;
    stall    = stall_rs | stall_rt | stall_md;
  end

  // Next slot contents: shift toward W with saturating tnew, load or bubble slot 1.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      valid_d[k] = 1'b0;
      dst_d[k]   = '0;
      tnew_d[k]  = '0;
    end
    if (!stall) begin
      valid_d[1] = d_valid;
      dst_d[1]   = d_wdst;
      tnew_d[1]  = d_tnew;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      dst_d[k]   = dst_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - 1'b1 : '0;
    end
    // A flush empties the whole window, including the incoming D instruction.
    if (flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_d[k] = 1'b0;
        dst_d[k]   = '0;
        tnew_d[k]  = '0;
      end
    end
  end

  // MDU busy counter: load on an accepted, unflushed start, else count down to 0.
  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    if (d_md_start && d_valid && !stall && !flush)
      cnt_d = d_md_div ? DIV_LD : MULT_LD;
  end

  // Slot and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        dst_q[k]   <= '0;
        tnew_q[k]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        dst_q[k]   <= dst_d[k];
        tnew_q[k]  <= tnew_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, 5, register address width.
REQ-002 Parameter DEPTH, 3, tracked stages after D (slot 1 = E … slot DEPTH = W); legal range 2..6.
REQ-003 Parameter TW, 3, Tuse/Tnew width; all-ones (7 at TW=3) = NOTUSE.
REQ-004 Parameter MULT_LAT, 5, multiply busy cycles.
REQ-005 Parameter DIV_LAT, 10, divide busy cycles.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 flush  in  1  clears all tracked slots (exception/eret).
REQ-009 d_valid  in  1  D-stage instruction valid.
REQ-010 d_rs, d_rt  in  REG_AW  source registers.
REQ-011 d_tuse_rs, d_tuse_rt  in  TW  Tuse per source; NOTUSE = no read.
REQ-012 d_wdst  in  REG_AW  destination register; 0 = no write.
REQ-013 d_tnew  in  TW  cycles after E entry until result is forwardable.
REQ-014 d_md_start, d_md_div  in  1 each  instruction starts mult/div; div selects DIV_LAT.
REQ-015 d_md_use  in  1  instruction needs idle MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-016 stall  out  1  hold F/D, inject bubble into E.
REQ-017 stall_rs, stall_rt, stall_md  out  1 each  stall cause breakdown.
REQ-018 md_busy  out  1  MDU counter nonzero.

Function
REQ-019 Each slot SHALL hold {valid, dst, tnew}; stall outputs are combinational from slots, counter and D inputs.
REQ-020 Every clock: slot k+1 SHALL take slot k with tnew decremented, saturating at 0; slot DEPTH contents retire.
REQ-021 Slot 1 SHALL load {d_valid, d_wdst, d_tnew} when stall=0, else a bubble (valid=0, dst=0, tnew=0).
REQ-022 A slot matches a source when valid, dst!=0, dst==source reg, and source Tuse!=NOTUSE.
REQ-023 stall_rs/stall_rt SHALL assert when d_valid and any slot 1..DEPTH matches under the REQ-034 rule.
REQ-024 MDU counter SHALL load MULT_LAT or DIV_LAT when d_md_start, d_valid and stall=0, else decrement to 0, saturating.
REQ-025 stall_md SHALL assert when d_valid, d_md_use and counter!=0.
REQ-026 stall SHALL equal stall_rs | stall_rt | stall_md; md_busy SHALL equal counter!=0.
REQ-027 flush SHALL clear all slot valid bits at the next edge and suppress the slot-1 load; MDU counter continues unaffected.
REQ-028 Simultaneous flush and d_md_start SHALL NOT load the counter.
REQ-029 d_wdst=0 SHALL never cause a stall; with d_valid=0 all stall outputs SHALL be 0.
REQ-030 Latency: a hazard resolves combinationally in the cycle the slot tnew satisfies the rule; no extra bubble.

Reset
REQ-031 reset low SHALL immediately clear all slots (valid=0, dst=0, tnew=0) and the MDU counter, independent of clk.
REQ-032 After reset every output SHALL be 0; reset during an active stall or MDU operation SHALL abandon it.
REQ-033 Release of reset SHALL take effect at the first rising edge after reset goes high.

Configuration
REQ-034 Macro HAZARD_FORWARD_EN: defined -> match stalls only when source Tuse < slot tnew; undefined -> any match in slots 1..DEPTH-1 stalls regardless of Tuse/Tnew (slot DEPTH writes through the register file); slot/counter logic identical in both builds.

Verification
REQ-035 FORWARD_EN, lw $8 (tnew=2) then addu rs=$8 (tuse=1) -> stall=1 for exactly 1 cycle, stall_rs=1, then 0.
REQ-036 FORWARD_EN, lw $8 then beq rs=$8 (tuse=0) -> stall=1 for 2 cycles; ori $8 (tnew=1) then beq $8 -> 1 cycle.
REQ-037 No FORWARD_EN, DEPTH=3, addu $9 then ori rs=$9 -> stall=1 for 2 cycles (slots 1,2), 0 once the entry reaches slot 3.
REQ-038 div (d_md_start, d_md_div) then mflo -> md_busy high 10 cycles, stall_md=1 for 10 cycles; mult then mfhi -> 5 cycles.
REQ-039 lw $8 in slot 1, flush pulse, then addu rs=$8 -> stall=0; d_wdst=0 producer followed by rs=$0 reader -> stall=0.
REQ-040 Assert reset low mid-divide (counter=6) asynchronously -> md_busy=0 and stall=0 before the next edge; resumes cleanly after release.
